issue_window_sched: RTL and testbench
=====================================

Name: issue_window_sched

Overview:
- N-slot issue window scheduler: accepts dispatched instructions, tracks operand wakeup from done_flags, selects the oldest fully-ready entry and issues it to one execution port over valid/ready.
- Sits between the dispatch/rename stage and a functional unit. Replaces a chain of single-slot issue entries with one shared, age-ordered select.

Parameters:
- INST_WIDTH, 47, instruction word width.
- N_SLOTS, 8, window depth (2..16).
- DONE_W, 30, width of the done_flags broadcast.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- done_flags  in  DONE_W  per-tag completion flags, level, sampled every cycle.
- flush  in  1  synchronous squash of all window contents.
- in_instr  in  INST_WIDTH  dispatched instruction.
- in_valid  in  1  dispatch valid.
- in_ready  out  1  window can accept this cycle.
- out_instr  out  INST_WIDTH  selected instruction, ready bits updated by wakeup.
- out_valid  out  1  a ready instruction is presented.
- out_ready  in  1  FU accepts.
- occupancy  out  $clog2(N_SLOTS+1)  number of valid slots.

Behaviour:
- Instruction fields:
  - 4 sources, i = 0..3.
  - Ready bit at [9+i].
  - Tag at [13+5i +: 5].
  - Tag 0 and tag 1 are always ready.
  - Tag t >= 2 is ready when done_flags[t-2] is set.
  - Tags with t-2 >= DONE_W never wake.
- Reset (rst=0, async): all slots invalid, age matrix cleared, lock cleared. Outputs: occupancy=0, in_ready=1, out_valid=0. out_instr is don't-care.
- Wakeup (combinational, sticky):
  - woken[k] = stored[k] with ready bit i ORed with tag-ready(i).
  - Stored word is updated with woken[k] every cycle.
  - Wakeup latency is 0: a done_flag seen this cycle can issue this cycle.
- Allocation:
  - in_ready = (occupancy < N_SLOTS) & !flush. It does not depend on out_ready.
  - On in_valid & in_ready, write the lowest-index free slot with in_instr, woken with the same cycle's done_flags.
  - An accepted instruction is not issuable until the next cycle (bypass only under the optional feature).
- Age matrix:
  - older[j][k]=1 means slot j is older than slot k.
  - On allocating slot k: older[k][*]=0 and older[*][k]=valid[*].
- Select:
  - rdy[k] = valid[k] & all four woken ready bits set.
  - Pick the slot k with rdy[k] and no rdy[j] with older[j][k].
  - out_instr = woken[k]; out_valid = any rdy.
- Lock:
  - If out_valid & !out_ready, the selected slot is latched.
  - The next cycle presents the same slot even if an older entry became ready.
  - Lock clears on acceptance or flush.
- Issue: on out_valid & out_ready the slot is invalid from the next edge. occupancy += alloc - issue, so simultaneous alloc and issue leaves it unchanged.
- Slot reuse: a slot freed this cycle is not reused until the next cycle.
- Full: occupancy == N_SLOTS gives in_ready=0; an issue that same cycle re-enables in_ready next cycle.
- Flush:
  - All slots are invalidated and the lock cleared at the next edge; occupancy=0.
  - in_ready=0 during the flush cycle; no allocation.
  - out_valid is still computed; an FU acceptance during flush is legal and the result is discarded by the consumer.
- Reset mid-handshake: state is dropped immediately and out_valid falls asynchronously.

Optional Feature:
- Macro ISSUE_WINDOW_BYPASS_EN.
- Defined:
  - If no slot is rdy, lock is clear, in_valid & in_ready, and the woken in_instr has all four ready bits set, then out_instr = woken in_instr and out_valid=1.
  - On out_ready the instruction is not written to any slot.
  - If not accepted, it is allocated normally and locked.
- Undefined: minimum dispatch-to-issue latency is 1 cycle.

Decomposition:
- Package issue_pkg: NUM_SRC=4, SRC_RDY_LSB=9, SRC_TAG_LSB=13, SRC_TAG_W=5, SRC_TAG_STRIDE=5, TAG_BIAS=2, DONE_W=30, INST_WIDTH=47; function src_ready(tag, done_flags).
- Sub-module issue_age_matrix: holds older[][], takes alloc_vld/alloc_idx, valid vector and rdy vector; outputs one-hot oldest-ready grant; async active-low reset.

Test Plan:
- Reset then single dispatch:
  - Stimulus: instr with all tags=0, then out_ready=1.
  - Response: cycle+1 out_valid=1, out_instr ready bits [12:9]=4'hF; after accept occupancy returns 0.
- Wakeup:
  - Stimulus: dispatch with src0 tag=7, others 0; hold 3 cycles; then pulse done_flags[5].
  - Response: out_valid=0 until the pulse, =1 in the same cycle; stays 1 after done_flags drops (sticky).
- Age order:
  - Stimulus: dispatch A, B, C (all waiting on tag 4); assert done_flags[2].
  - Response: issue order A, B, C on consecutive cycles with out_ready=1.
- Lock:
  - Stimulus: B ready with out_ready=0; then older A wakes.
  - Response: out_instr remains B until accepted, then A.
- Full/flush:
  - Stimulus: fill 8 slots.
  - Response: in_ready=0, occupancy=8.
  - Stimulus: flush for 1 cycle.
  - Response: occupancy=0, out_valid=0, in_ready=1 next cycle.
- Async reset:
  - Stimulus: drop rst mid-cycle with 3 entries and out_valid=1.
  - Response: out_valid=0 and occupancy=0 before the next edge.

Source files
------------

// File: rtl/issue_window_sched_pkg.sv
// Shared field layout and operand wakeup helper for the issue window scheduler.
package issue_pkg;

    localparam int NUM_SRC        = 4;
    localparam int SRC_RDY_LSB    = 9;
    localparam int SRC_TAG_LSB    = 13;
    localparam int SRC_TAG_W      = 5;
    localparam int SRC_TAG_STRIDE = 5;
    localparam int TAG_BIAS       = 2;
    localparam int DONE_W         = 30;
    localparam int INST_WIDTH     = 47;

    // Tags below TAG_BIAS are architecturally always ready; tags past the flag range never wake.
    function automatic logic src_ready(input logic [SRC_TAG_W-1:0] tag,
                                       input logic [DONE_W-1:0]    doneFlags);
        logic r;
        r = 1'b0;
        if (tag < SRC_TAG_W'(TAG_BIAS)) begin
            r = 1'b1;
        end else begin
            for (int t = 0; t < DONE_W; t++) begin
                if (tag == SRC_TAG_W'(t + TAG_BIAS)) begin
                    r = doneFlags[t];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_window_sched_age_matrix.sv
// Age matrix for the issue window: tracks relative slot age and grants the oldest ready slot.
module issue_age_matrix
    import issue_pkg::*;
#(
    parameter int N_SLOTS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_vld_i,
    input  logic [$clog2(N_SLOTS)-1:0] alloc_idx_i,
    input  logic [N_SLOTS-1:0]         valid_i,
    input  logic [N_SLOTS-1:0]         rdy_i,
    output logic [N_SLOTS-1:0]         grant_o
);

    localparam int IDX_W = $clog2(N_SLOTS);

    logic [N_SLOTS-1:0] older_q [N_SLOTS];
    logic [N_SLOTS-1:0] older_d [N_SLOTS];
    logic [N_SLOTS-1:0] blocked;

    // A new entry is younger than everything currently valid and older than nothing.
    always_comb begin
        for (int j = 0; j < N_SLOTS; j++) begin
            older_d[j] = older_q[j];
        end
        if (alloc_vld_i) begin
            for (int j = 0; j < N_SLOTS; j++) begin
                if (IDX_W'(j) == alloc_idx_i) begin
                    older_d[j] = '0;
                end else begin
                    older_d[j][alloc_idx_i] = valid_i[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < N_SLOTS; j++) begin
                older_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_SLOTS; j++) begin
                older_q[j] <= older_d[j];
            end
        end
    end

    always_comb begin
        blocked = '0;
        grant_o = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            for (int j = 0; j < N_SLOTS; j++) begin
                if (rdy_i[j] && older_q[j][k]) begin
                    blocked[k] = 1'b1;
                end
            end
            grant_o[k] = rdy_i[k] & ~blocked[k];
        end
    end

endmodule

// File: rtl/issue_window_sched.sv
// Age-ordered N-slot issue window with sticky operand wakeup and a single valid/ready issue port.
// Optional same-cycle dispatch bypass is enabled by defining ISSUE_WINDOW_BYPASS_EN.
module issue_window_sched #(
    parameter int INST_WIDTH = 47,
    parameter int N_SLOTS    = 8,
    parameter int DONE_W     = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DONE_W-1:0]              done_flags,
    input  logic                           flush,
    input  logic [INST_WIDTH-1:0]          in_instr,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [INST_WIDTH-1:0]          out_instr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(N_SLOTS+1)-1:0]   occupancy
);

    import issue_pkg::*;

    localparam int IDX_W      = $clog2(N_SLOTS);
    localparam int CNT_W      = $clog2(N_SLOTS + 1);
    localparam int PKG_DONE_W = issue_pkg::DONE_W;
    localparam int MIN_DONE_W = (DONE_W < PKG_DONE_W) ? DONE_W : PKG_DONE_W;

    logic [INST_WIDTH-1:0] slot_q  [N_SLOTS];
    logic [INST_WIDTH-1:0] slot_d  [N_SLOTS];
    logic [INST_WIDTH-1:0] woken   [N_SLOTS];
    logic [N_SLOTS-1:0]    valid_q, valid_d;
    logic                  lock_q, lock_d;
    logic [IDX_W-1:0]      lockIdx_q, lockIdx_d;

    logic [PKG_DONE_W-1:0] doneFlagsPkg;
    logic [INST_WIDTH-1:0] wokenIn;
    logic [N_SLOTS-1:0]    rdy;
    logic [N_SLOTS-1:0]    grant;
    logic [IDX_W-1:0]      grantIdx, selIdx, freeIdx;
    logic                  anyRdy, bypassSel, allocFire, issueFire;
    logic [CNT_W-1:0]      occCount;

    function automatic logic [INST_WIDTH-1:0] wake(input logic [INST_WIDTH-1:0] w,
                                                  input logic [PKG_DONE_W-1:0] f);
        logic [INST_WIDTH-1:0] r;
        r = w;
        for (int i = 0; i < NUM_SRC; i++) begin
            r[SRC_RDY_LSB + i] = w[SRC_RDY_LSB + i] |
                                 src_ready(w[SRC_TAG_LSB + SRC_TAG_STRIDE*i +: SRC_TAG_W], f);
        end
        return r;
    endfunction

    function automatic logic all_ready(input logic [INST_WIDTH-1:0] w);
        return &w[SRC_RDY_LSB +: NUM_SRC];
    endfunction

    always_comb begin
        doneFlagsPkg = '0;
        for (int t = 0; t < MIN_DONE_W; t++) begin
            doneFlagsPkg[t] = done_flags[t];
        end
        wokenIn = wake(in_instr, doneFlagsPkg);
        for (int k = 0; k < N_SLOTS; k++) begin
            woken[k] = wake(slot_q[k], doneFlagsPkg);
            rdy[k]   = valid_q[k] & all_ready(woken[k]);
        end
        anyRdy = |rdy;
    end

    issue_age_matrix #(
        .N_SLOTS (N_SLOTS)
    ) u_age (
        .clk_i       (clk),
        .rst_ni      (rst),
        .alloc_vld_i (allocFire),
        .alloc_idx_i (freeIdx),
        .valid_i     (valid_q),
        .rdy_i       (rdy),
        .grant_o     (grant)
    );

    always_comb begin
        grantIdx = '0;
        freeIdx  = '0;
        occCount = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (grant[k]) begin
                grantIdx = IDX_W'(k);
            end
            if (!valid_q[k]) begin
                freeIdx = IDX_W'(k);
            end
        end
        for (int k = 0; k < N_SLOTS; k++) begin
            occCount = occCount + CNT_W'(valid_q[k]);
        end
    end

    assign occupancy = occCount;
    assign in_ready  = (occCount < CNT_W'(N_SLOTS)) & ~flush;

    // A latched slot keeps the port even if an older entry wakes while the FU stalls.
    always_comb begin
        selIdx    = lock_q ? lockIdx_q : grantIdx;
        out_instr = woken[selIdx];
        out_valid = lock_q | anyRdy;
        bypassSel = 1'b0;
`ifdef ISSUE_WINDOW_BYPASS_EN
        if (!anyRdy && !lock_q && in_valid && in_ready && all_ready(wokenIn)) begin
            bypassSel = 1'b1;
            out_instr = wokenIn;
            out_valid = 1'b1;
        end
`endif
        issueFire = out_valid & out_ready;
        allocFire = in_valid & in_ready & ~(bypassSel & out_ready);
    end

    always_comb begin
        valid_d   = valid_q;
        lock_d    = lock_q;
        lockIdx_d = lockIdx_q;
        for (int k = 0; k < N_SLOTS; k++) begin
            slot_d[k] = woken[k];
        end
        if (issueFire && !bypassSel) begin
            valid_d[selIdx] = 1'b0;
        end
        if (allocFire) begin
            slot_d[freeIdx]  = wokenIn;
            valid_d[freeIdx] = 1'b1;
        end
        if (out_valid && !out_ready) begin
            lock_d    = 1'b1;
            lockIdx_d = bypassSel ? freeIdx : selIdx;
        end else if (issueFire) begin
            lock_d = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
            valid_q   <= '0;
            lock_q    <= 1'b0;
            lockIdx_q <= '0;
        end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            lockIdx_q <= lockIdx_d;
        end
    end

endmodule

// File: tb/tb_issue_window_sched.sv
// Directed self-checking bench for issue_window_sched (default build, bypass disabled).
module tb_issue_window_sched;

    localparam int INST_W = 47;
    localparam int SLOTS  = 8;
    localparam int DW     = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     doneFlags;
    logic              flush;
    logic [INST_W-1:0] inInstr;
    logic              inValid;
    logic              inReady;
    logic [INST_W-1:0] outInstr;
    logic              outValid;
    logic              outReady;
    logic [3:0]        occupancy;

    int checkCount = 0;
    int failCount  = 0;

    issue_window_sched #(
        .INST_WIDTH (INST_W),
        .N_SLOTS    (SLOTS),
        .DONE_W     (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done_flags (doneFlags),
        .flush      (flush),
        .in_instr   (inInstr),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .out_instr  (outInstr),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [INST_W-1:0] instr,
                                 input logic oRdy, input logic fl, input logic [DW-1:0] done);
        inValid   = vld;
        inInstr   = instr;
        outReady  = oRdy;
        flush     = fl;
        doneFlags = done;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INST_W-1:0] mkInstr(input logic [7:0] id, input logic [4:0] t0,
                                                 input logic [4:0] t1, input logic [4:0] t2,
                                                 input logic [4:0] t3);
        logic [INST_W-1:0] w;
        w        = '0;
        w[7:0]   = id;
        w[17:13] = t0;
        w[22:18] = t1;
        w[27:23] = t2;
        w[32:28] = t3;
        w[46:39] = id;
        return w;
    endfunction

    function automatic logic [63:0] woke(input logic [INST_W-1:0] w);
        logic [INST_W-1:0] r;
        r       = w;
        r[12:9] = 4'hF;
        return 64'(r);
    endfunction

    function automatic logic [DW-1:0] bitOf(input int n);
        logic [DW-1:0] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    logic [INST_W-1:0] instrA, instrB, instrC, instrD;
    logic [INST_W-1:0] zeroInstr;

    initial begin
        zeroInstr = '0;
        rst = 1'b0;
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #12;
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single dispatch, issuable one cycle later
        instrA = mkInstr(8'h01, 5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, instrA, 1'b0, 1'b0, '0);
        #1;
        checkOutput("disp_in_ready", 64'(inReady), 64'd1);
        checkOutput("disp_no_same_cycle", 64'(outValid), 64'd0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("disp_out_valid", 64'(outValid), 64'd1);
        checkOutput("disp_out_instr", 64'(outInstr), woke(instrA));
        checkOutput("disp_occupancy", 64'(occupancy), 64'd1);
        applyStimulus(1'b0, zeroInstr, 1'b1, 1'b0, '0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("disp_drained_occ", 64'(occupancy), 64'd0);
        checkOutput("disp_drained_valid", 64'(outValid), 64'd0);

        // wakeup from done_flags[5] (tag 7), sticky afterwards
        instrB = mkInstr(8'h02, 5'd7, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, instrB, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("wake_waiting", 64'(outValid), 64'd0);
            step();
        end
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, bitOf(5));
        #1;
        checkOutput("wake_same_cycle", 64'(outValid), 64'd1);
        checkOutput("wake_instr", 64'(outInstr), woke(instrB));
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("wake_sticky", 64'(outValid), 64'd1);
        checkOutput("wake_sticky_instr", 64'(outInstr), woke(instrB));
        applyStimulus(1'b0, zeroInstr, 1'b1, 1'b0, '0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("wake_drained_occ", 64'(occupancy), 64'd0);

        // age order A, B, C waiting on tag 4
        instrA = mkInstr(8'h10, 5'd4, 5'd0, 5'd0, 5'd0);
        instrB = mkInstr(8'h11, 5'd4, 5'd0, 5'd0, 5'd0);
        instrC = mkInstr(8'h12, 5'd4, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, instrA, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b1, instrB, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b1, instrC, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b1, 1'b0, bitOf(2));
        #1;
        checkOutput("age_first", 64'(outInstr), woke(instrA));
        step();
        checkOutput("age_second", 64'(outInstr), woke(instrB));
        step();
        checkOutput("age_third", 64'(outInstr), woke(instrC));
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("age_empty_valid", 64'(outValid), 64'd0);
        checkOutput("age_empty_occ", 64'(occupancy), 64'd0);

        // age order where a reused low slot holds the youngest entry
        instrA = mkInstr(8'h30, 5'd0, 5'd0, 5'd0, 5'd0);
        instrB = mkInstr(8'h31, 5'd11, 5'd0, 5'd0, 5'd0);
        instrC = mkInstr(8'h32, 5'd11, 5'd0, 5'd0, 5'd0);
        instrD = mkInstr(8'h33, 5'd11, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, instrA, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b1, instrB, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b1, instrC, 1'b1, 1'b0, '0);
        #1;
        checkOutput("reuse_issue_head", 64'(outInstr), woke(instrA));
        step();
        applyStimulus(1'b1, instrD, 1'b0, 1'b0, '0);
        #1;
        checkOutput("reuse_alloc_issue_occ", 64'(occupancy), 64'd2);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b1, 1'b0, bitOf(9));
        #1;
        checkOutput("reuse_order_1", 64'(outInstr), woke(instrB));
        step();
        checkOutput("reuse_order_2", 64'(outInstr), woke(instrC));
        step();
        checkOutput("reuse_order_3", 64'(outInstr), woke(instrD));
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("reuse_empty_occ", 64'(occupancy), 64'd0);

        // lock: younger B presented while stalled, older A wakes later
        instrA = mkInstr(8'h20, 5'd8, 5'd0, 5'd0, 5'd0);
        instrB = mkInstr(8'h21, 5'd9, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, instrA, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b1, instrB, 1'b0, 1'b0, '0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, bitOf(7));
        #1;
        checkOutput("lock_young_ready", 64'(outInstr), woke(instrB));
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, bitOf(7) | bitOf(6));
        #1;
        checkOutput("lock_hold", 64'(outInstr), woke(instrB));
        step();
        applyStimulus(1'b0, zeroInstr, 1'b1, 1'b0, bitOf(7) | bitOf(6));
        #1;
        checkOutput("lock_accept", 64'(outInstr), woke(instrB));
        step();
        checkOutput("lock_then_older", 64'(outInstr), woke(instrA));
        checkOutput("lock_then_older_valid", 64'(outValid), 64'd1);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("lock_drained_occ", 64'(occupancy), 64'd0);

        // fill all slots, then flush
        for (int i = 0; i < SLOTS; i++) begin
            applyStimulus(1'b1, mkInstr(8'(8'h40 + i), 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, '0);
            #1;
            checkOutput("fill_in_ready", 64'(inReady), 64'd1);
            step();
        end
        applyStimulus(1'b1, mkInstr(8'h50, 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, '0);
        #1;
        checkOutput("full_in_ready", 64'(inReady), 64'd0);
        checkOutput("full_occupancy", 64'(occupancy), 64'd8);
        checkOutput("full_out_valid", 64'(outValid), 64'd0);
        step();
        checkOutput("full_hold_occ", 64'(occupancy), 64'd8);
        applyStimulus(1'b1, mkInstr(8'h51, 5'd0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b1, '0);
        #1;
        checkOutput("flush_in_ready", 64'(inReady), 64'd0);
        step();
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        checkOutput("flush_out_valid", 64'(outValid), 64'd0);
        checkOutput("flush_in_ready_after", 64'(inReady), 64'd1);

        // asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkInstr(8'(8'h60 + i), 5'd0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, '0);
            step();
        end
        applyStimulus(1'b0, zeroInstr, 1'b0, 1'b0, '0);
        #1;
        checkOutput("arst_pre_valid", 64'(outValid), 64'd1);
        checkOutput("arst_pre_occ", 64'(occupancy), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(outValid), 64'd0);
        checkOutput("arst_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        checkOutput("arst_in_ready", 64'(inReady), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
